// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: sequences one UART transmit frame (start, LSB-first data,
// optional parity, stop) and steers the serializer, parity calculator and
// 4:1 output mux. clk is the baud clock, so every state cycle is one bit time.
module uart_tx_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       data_valid,
    input  logic       par_en,
    output logic       ser_load,
    output logic       par_load,
    output logic       ser_shift,
    output logic [1:0] mux_sel,
    output logic       busy
);

    // Output-mux select codes.
    localparam logic [1:0] MUX_LINE_HI = 2'b00;
    localparam logic [1:0] MUX_START   = 2'b01;
    localparam logic [1:0] MUX_DATA    = 2'b10;
    localparam logic [1:0] MUX_PARITY  = 2'b11;

    // Counter value on the last data bit of a frame.
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    state_t                 state_reg;
    state_t                 state_next;
    logic [CNT_WIDTH-1:0]   cnt_reg;
    logic [CNT_WIDTH-1:0]   cnt_next;
    logic                   par_en_q_reg;
    logic                   par_en_q_next;
    logic                   accept;

    logic [1:0]             mux_sel_reg;
    logic                   busy_reg;
    logic                   ser_shift_reg;

    // Moore output decode of a state value; applied to the next state so the
    // registered outputs always match the state register.
    function automatic logic [3:0] decode_outputs(input state_t st);
        // {busy, ser_shift, mux_sel}
        logic [3:0] res;
        case (st)
            ST_START:  res = {1'b1, 1'b0, MUX_START};
            ST_DATA:   res = {1'b1, 1'b1, MUX_DATA};
            ST_PARITY: res = {1'b1, 1'b0, MUX_PARITY};
            ST_STOP:   res = {1'b1, 1'b0, MUX_LINE_HI};
            default:   res = {1'b0, 1'b0, MUX_LINE_HI};
        endcase
        return res;
    endfunction

    // A frame is accepted from IDLE or, back-to-back, from STOP. Gated by the
    // reset so no load strobe escapes while the block is held in reset.
    always_comb begin
        accept = rst && data_valid &&
                 ((state_reg == ST_IDLE) || (state_reg == ST_STOP));
    end

    // Load strobes are the only Mealy outputs: they fire in the accept cycle.
    assign ser_load  = accept;
    assign par_load  = accept;

    assign mux_sel   = mux_sel_reg;
    assign busy      = busy_reg;
    assign ser_shift = ser_shift_reg;

    // Next-state, bit-counter and parity-enable capture logic.
    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        par_en_q_next = par_en_q_reg;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    state_next    = ST_START;
                    par_en_q_next = par_en;
                end
            end
            ST_START: begin
                state_next = ST_DATA;
                cnt_next   = '0;
            end
            ST_DATA: begin
                if (cnt_reg == CNT_LAST) begin
                    cnt_next   = '0;
                    state_next = par_en_q_reg ? ST_PARITY : ST_STOP;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            ST_PARITY: begin
                state_next = ST_STOP;
            end
            ST_STOP: begin
                if (accept) begin
                    state_next    = ST_START;
                    par_en_q_next = par_en;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                // Unreachable encodings fall back to a quiet idle line.
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // State register plus registered Moore outputs; reset aborts any frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            par_en_q_reg  <= 1'b0;
            mux_sel_reg   <= MUX_LINE_HI;
            busy_reg      <= 1'b0;
            ser_shift_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            par_en_q_reg  <= par_en_q_next;
            {busy_reg, ser_shift_reg, mux_sel_reg} <= decode_outputs(state_next);
        end
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: an 8-bit and a 5-bit instance share stimulus; a
// frame-position model predicts every output each cycle.
module tb_uart_tx_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       data_valid = 1'b0;
    logic       par_en = 1'b0;

    logic [1:0] ser_load_v;
    logic [1:0] par_load_v;
    logic [1:0] ser_shift_v;
    logic [1:0] busy_v;
    logic [3:0] mux_v;

    int checks = 0;
    int errors = 0;

    // Reference model: per instance, whether a frame is on the line, the bit
    // position within it (0 = start bit) and the parity choice for that frame.
    bit in_frame [2];
    int pos      [2];
    bit par_q    [2];
    int busy_cnt [2];
    int shift_cnt[2];
    int load_cnt [2];
    int par_cnt  [2];

    always #5 clk = ~clk;

    uart_tx_ctrl #(.DATA_WIDTH(8), .CNT_WIDTH(4)) u8 (
        .clk(clk), .rst(rst), .data_valid(data_valid), .par_en(par_en),
        .ser_load(ser_load_v[0]), .par_load(par_load_v[0]),
        .ser_shift(ser_shift_v[0]), .mux_sel(mux_v[1:0]), .busy(busy_v[0])
    );

    uart_tx_ctrl #(.DATA_WIDTH(5), .CNT_WIDTH(3)) u5 (
        .clk(clk), .rst(rst), .data_valid(data_valid), .par_en(par_en),
        .ser_load(ser_load_v[1]), .par_load(par_load_v[1]),
        .ser_shift(ser_shift_v[1]), .mux_sel(mux_v[3:2]), .busy(busy_v[1])
    );

    function automatic int width_of(input int i);
        return (i == 0) ? 8 : 5;
    endfunction

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_counts();
        for (int i = 0; i < 2; i++) begin
            busy_cnt[i] = 0; shift_cnt[i] = 0; load_cnt[i] = 0; par_cnt[i] = 0;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            in_frame[i] = 0; pos[i] = 0; par_q[i] = 0;
        end
    endtask

    // One baud cycle: check at the falling edge, advance model at the rising edge.
    task automatic cycle(input string what);
        bit acc [2];
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            int w = width_of(i);
            int len = w + 2 + (par_q[i] ? 1 : 0);
            logic [1:0] e_mux;
            bit e_shift;
            e_mux = 2'b00;
            e_shift = 0;
            if (in_frame[i]) begin
                if (pos[i] == 0) e_mux = 2'b01;
                else if (pos[i] <= w) begin e_mux = 2'b10; e_shift = 1; end
                else if (par_q[i] && pos[i] == w + 1) e_mux = 2'b11;
            end
            acc[i] = data_valid && (!in_frame[i] || pos[i] == len - 1);
            check($sformatf("%s u%0d mux", what, w), 8'(mux_v[2*i +: 2]), 8'(e_mux));
            check($sformatf("%s u%0d busy", what, w), 8'(busy_v[i]), 8'(in_frame[i]));
            check($sformatf("%s u%0d shift", what, w), 8'(ser_shift_v[i]), 8'(e_shift));
            check($sformatf("%s u%0d ser_load", what, w), 8'(ser_load_v[i]), 8'(acc[i]));
            check($sformatf("%s u%0d par_load", what, w), 8'(par_load_v[i]), 8'(acc[i]));
            busy_cnt[i]  += int'(busy_v[i]);
            shift_cnt[i] += int'(ser_shift_v[i]);
            load_cnt[i]  += int'(ser_load_v[i]);
            par_cnt[i]   += (mux_v[2*i +: 2] == 2'b11) ? 1 : 0;
        end
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            int len = width_of(i) + 2 + (par_q[i] ? 1 : 0);
            if (acc[i]) begin
                in_frame[i] = 1; pos[i] = 0; par_q[i] = par_en;
            end else if (in_frame[i]) begin
                pos[i]++;
                if (pos[i] >= len) begin in_frame[i] = 0; pos[i] = 0; end
            end
        end
        #1;
    endtask

    initial begin
        model_reset();
        clear_counts();
        data_valid = 1'b1;  // load strobes must stay low while in reset
        repeat (2) @(posedge clk);
        #1;
        check("reset mux", 8'(mux_v), 8'h0);
        check("reset busy", 8'(busy_v), 8'h0);
        check("reset shift", 8'(ser_shift_v), 8'h0);
        check("reset load", 8'({ser_load_v, par_load_v}), 8'h0);
        data_valid = 1'b0;
        rst = 1'b1;
        repeat (2) cycle("idle");

        // Single frame without parity.
        clear_counts();
        data_valid = 1'b1; par_en = 1'b0;
        cycle("f1");
        data_valid = 1'b0;
        repeat (12) cycle("f1");
        check("f1 busy cycles", 8'(busy_cnt[0]), 8'd10);
        check("f1 shift cycles", 8'(shift_cnt[0]), 8'd8);
        check("f1 loads", 8'(load_cnt[0]), 8'd1);
        check("f1 parity cycles", 8'(par_cnt[0]), 8'd0);

        // Single frame with parity; the 5-bit build gives an 8-clock frame.
        clear_counts();
        data_valid = 1'b1; par_en = 1'b1;
        cycle("f2");
        data_valid = 1'b0; par_en = 1'b0;
        repeat (12) cycle("f2");
        check("f2 busy cycles", 8'(busy_cnt[0]), 8'd11);
        check("f2 parity cycles", 8'(par_cnt[0]), 8'd1);
        check("f2 w5 busy cycles", 8'(busy_cnt[1]), 8'd8);
        check("f2 w5 shift cycles", 8'(shift_cnt[1]), 8'd5);

        // Three back-to-back frames with data_valid held high.
        clear_counts();
        data_valid = 1'b1; par_en = 1'b0;
        repeat (21) cycle("b2b");
        data_valid = 1'b0;
        repeat (12) cycle("b2b");
        check("b2b loads", 8'(load_cnt[0]), 8'd3);
        check("b2b busy cycles", 8'(busy_cnt[0]), 8'd30);

        // par_en dropped and data_valid pulsed mid-frame are ignored.
        clear_counts();
        data_valid = 1'b1; par_en = 1'b1;
        cycle("pchg");
        data_valid = 1'b0; par_en = 1'b0;
        repeat (3) cycle("pchg");
        data_valid = 1'b1;
        repeat (2) cycle("pchg");
        data_valid = 1'b0;
        repeat (10) cycle("pchg");
        check("pchg loads", 8'(load_cnt[0]), 8'd1);
        check("pchg parity cycles", 8'(par_cnt[0]), 8'd1);

        // Asynchronous reset during the fourth data bit.
        data_valid = 1'b1; par_en = 1'b0;
        cycle("rst");
        data_valid = 1'b0;
        repeat (4) cycle("rst");
        #2 rst = 1'b0;
        #1;
        check("async rst mux", 8'(mux_v), 8'h0);
        check("async rst busy", 8'(busy_v), 8'h0);
        check("async rst shift", 8'(ser_shift_v), 8'h0);
        model_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        clear_counts();
        data_valid = 1'b1;
        cycle("post rst");
        data_valid = 1'b0;
        repeat (12) cycle("post rst");
        check("post rst busy cycles", 8'(busy_cnt[0]), 8'd10);
        check("post rst shift cycles", 8'(shift_cnt[0]), 8'd8);

        // Randomized traffic checked cycle by cycle against the model.
        for (int n = 0; n < 400; n++) begin
            data_valid = ($urandom_range(0, 2) == 0);
            par_en     = 1'($urandom);
            cycle("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
- FSM that sequences one UART transmit frame: start bit, data bits LSB-first, optional parity bit, stop bit.
- Drives the serializer's load/shift strobes, the parity calculator's load strobe, and the 4:1 output-mux select.
- Sits between the Tx front-end handshake (data_valid/busy) and the Tx datapath (serializer, parity calculator, output mux).
- clk is the baud-rate clock: one clock per transmitted bit.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame. Legal range 5..9.
- CNT_WIDTH, 4, width of the internal bit counter. Must satisfy 2^CNT_WIDTH > DATA_WIDTH.

Ports:
- clk  input  1  baud clock; all state updates on rising edge.
- rst  input  1  asynchronous active-low reset.
- data_valid  input  1  front-end has a byte ready; sampled only when the FSM can accept.
- par_en  input  1  parity-bit enable; sampled only at frame accept.
- ser_load  output  1  combinational; one-cycle pulse to load the serializer with the input byte.
- par_load  output  1  combinational; one-cycle pulse to load the parity calculator. Identical timing to ser_load.
- ser_shift  output  1  serializer shift enable; high during every DATA-state cycle.
- mux_sel  output  2  output-mux select: 00 = idle/stop (line 1), 01 = start (line 0), 10 = serial data, 11 = parity.
- busy  output  1  high while a frame is in progress.

Behaviour:
- States: IDLE, START, DATA, PARITY, STOP. Each state except DATA lasts exactly one clock. DATA lasts DATA_WIDTH clocks.
- Reset (async, rst=0): state=IDLE, bit counter=0, par_en_q=0. Outputs: busy=0, mux_sel=00, ser_shift=0, ser_load=0, par_load=0.
- Reset mid-frame aborts the frame immediately; the line returns to 1 (mux_sel=00) with no stop bit emitted.
- Accept condition:
  - The FSM accepts a frame when in IDLE, or in STOP, and data_valid=1.
  - On accept, ser_load=1 and par_load=1 combinationally in that same cycle.
  - par_en_q <= par_en.
  - Next state = START.
- IDLE: mux_sel=00, busy=0. If data_valid=0, stay in IDLE.
- START: mux_sel=01, busy=1, counter <= 0, next state = DATA.
- DATA:
  - mux_sel=10, ser_shift=1, busy=1.
  - Counter increments each cycle.
  - When counter == DATA_WIDTH-1: go to PARITY if par_en_q=1, else STOP; counter <= 0.
- PARITY: mux_sel=11, busy=1, next state = STOP. The parity result is valid here because it is registered one cycle after par_load and at least DATA_WIDTH+1 cycles elapse before PARITY.
- STOP: mux_sel=00, busy=1.
  - If data_valid=1, accept back-to-back: next state = START with no idle gap.
  - Otherwise go to IDLE.
- Outputs mux_sel, busy and ser_shift are pure decodes of the state register (Moore). Only ser_load and par_load depend on data_valid.
- data_valid high in START, DATA or PARITY is ignored; the front-end must hold it until accepted.
- par_en changes after accept have no effect on the current frame.
- Frame length: DATA_WIDTH+2 clocks without parity, DATA_WIDTH+3 clocks with parity.
- busy rises on the clock edge after accept and stays high through STOP. It falls on the edge that leaves STOP to IDLE.
- The counter never exceeds DATA_WIDTH-1. Illegal state encodings recover to IDLE on the next clock.

Test Plan:
- Reset, then data_valid=1 for one cycle with par_en=0, DATA_WIDTH=8 -> ser_load/par_load pulse in the accept cycle; mux_sel sequence 01, then 10 ×8, then 00; busy high for exactly 10 cycles; ser_shift high exactly 8 cycles.
- Same stimulus with par_en=1 -> mux_sel sequence 01, 10 ×8, 11, 00; busy high for 11 cycles.
- data_valid held high continuously for 3 frames with par_en=0 -> frames of 10 cycles each with no IDLE cycle between; 3 load pulses, each in a STOP cycle except the first; busy never drops until after the third STOP.
- Accept with par_en=1, then drop par_en to 0 and pulse data_valid during DATA -> current frame still contains a PARITY cycle; no extra load pulse during the frame.
- Assert rst=0 asynchronously on the 4th DATA cycle -> mux_sel=00 and busy=0 immediately; FSM in IDLE; a new data_valid after release starts a clean 10-cycle frame.
- DATA_WIDTH=5 build with par_en=1 -> exactly 5 ser_shift cycles; total frame length 8 clocks.
